// File: rtl/keypad_scanner_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scanner_pkg
//   Shared definitions for the 4x3 keypad scanner and its consumers.
//   - Key code constants (ZERO..NINE, STAR, HASH, NO_KEY). The manager and the
//     testbench use these same constants.
//   - Scanner FSM state type.
//   - Helpers: single-column-low detection, column index and key encoding.
// -----------------------------------------------------------------------------
package keypad_scanner_pkg;

    localparam logic [3:0] KEY_ZERO  = 4'd0;
    localparam logic [3:0] KEY_ONE   = 4'd1;
    localparam logic [3:0] KEY_TWO   = 4'd2;
    localparam logic [3:0] KEY_THREE = 4'd3;
    localparam logic [3:0] KEY_FOUR  = 4'd4;
    localparam logic [3:0] KEY_FIVE  = 4'd5;
    localparam logic [3:0] KEY_SIX   = 4'd6;
    localparam logic [3:0] KEY_SEVEN = 4'd7;
    localparam logic [3:0] KEY_EIGHT = 4'd8;
    localparam logic [3:0] KEY_NINE  = 4'd9;
    localparam logic [3:0] KEY_STAR  = 4'b1010;
    localparam logic [3:0] KEY_HASH  = 4'b1011;
    localparam logic [3:0] NO_KEY    = 4'b1111;

    typedef enum logic [2:0] {
        SCAN,
        DEB_PRESS,
        PRESSED,
        WAIT_REL,
        DEB_REL
    } scan_state_t;

    // True when exactly one of the three active-low columns is pulled low.
    function automatic logic one_low(input logic [2:0] pat);
        return (pat == 3'b110) || (pat == 3'b101) || (pat == 3'b011);
    endfunction

    // Column index of a single-low pattern.
    function automatic logic [1:0] col_index(input logic [2:0] pat);
        logic [1:0] idx;
        case (pat)
            3'b110:  idx = 2'd0;
            3'b101:  idx = 2'd1;
            default: idx = 2'd2;
        endcase
        return idx;
    endfunction

    // Layout: r0 "1 2 3", r1 "4 5 6", r2 "7 8 9", r3 "* 0 #".
    function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = KEY_ONE;
            4'b00_01: code = KEY_TWO;
            4'b00_10: code = KEY_THREE;
            4'b01_00: code = KEY_FOUR;
            4'b01_01: code = KEY_FIVE;
            4'b01_10: code = KEY_SIX;
            4'b10_00: code = KEY_SEVEN;
            4'b10_01: code = KEY_EIGHT;
            4'b10_10: code = KEY_NINE;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = KEY_ZERO;
            4'b11_10: code = KEY_HASH;
            default:  code = NO_KEY;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a bus of independent, slowly changing bits.
//   Ports:
//     clk  in   1      destination clock
//     rst  in   1      synchronous, active-high reset (loads RESET_VALUE)
//     d    in   WIDTH  asynchronous input
//     q    out  WIDTH  synchronised output, two clk cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int                WIDTH       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x3 matrix keypad, synchronises and debounces the columns and
//   reports one key code per physical press.
//   Ports:
//     clk        in   1  system clock
//     rst        in   1  synchronous, active-high reset
//     col_n      in   3  keypad columns, active-low, pulled up, asynchronous
//     row_n      out  4  row drive, active-low, exactly one bit low
//     key_code   out  4  code of the last accepted key, holds between presses
//     key_valid  out  1  one-cycle pulse, key_code is new this cycle
//     key_held   out  1  high from acceptance until the release is debounced
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV        = 4000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    import keypad_scanner_pkg::*;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);

    logic [2:0]       col_s;
    scan_state_t      state_q, state_d;
    logic [1:0]       row_q;
    logic [DIV_W-1:0] div_q;
    logic [DEB_W-1:0] deb_q;
    logic [2:0]       pat_q;

    logic advance_row;
    logic latch_pat;
    logic div_clr;
    logic deb_clr;
    logic deb_inc;
    logic load_code;

    sync_2ff #(
        .WIDTH       (3),
        .RESET_VALUE (3'b111)
    ) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (col_n),
        .q   (col_s)
    );

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        advance_row = 1'b0;
        latch_pat   = 1'b0;
        div_clr     = 1'b0;
        deb_clr     = 1'b0;
        deb_inc     = 1'b0;
        load_code   = 1'b0;

        case (state_q)
            SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_clr = 1'b1;
                    if (one_low(col_s)) begin
                        latch_pat = 1'b1;
                        deb_clr   = 1'b1;
                        state_d   = DEB_PRESS;
                    end else begin
                        // Nothing or several keys in this row: move on.
                        advance_row = 1'b1;
                    end
                end
            end

            DEB_PRESS: begin
                if (col_s != pat_q) begin
                    advance_row = 1'b1;
                    state_d     = SCAN;
                end else begin
                    deb_inc = 1'b1;
                    if (deb_q >= DEB_LAST) begin
                        load_code = 1'b1;
                        state_d   = PRESSED;
                    end
                end
            end

            PRESSED: begin
                state_d = WAIT_REL;
            end

            WAIT_REL: begin
                if (col_s == 3'b111) begin
                    deb_clr = 1'b1;
                    state_d = DEB_REL;
                end
            end

            DEB_REL: begin
                if (col_s != 3'b111) begin
                    state_d = WAIT_REL;
                end else begin
                    deb_inc = 1'b1;
                    if (deb_q >= DEB_LAST) begin
                        advance_row = 1'b1;
                        state_d     = SCAN;
                    end
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // NOTE: reset is synchronous, so it sits inside the clocked branch and is
    // only honoured on a rising edge of clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SCAN;
            row_q    <= 2'd0;
            div_q    <= '0;
            deb_q    <= '0;
            pat_q    <= 3'b111;
            key_code <= NO_KEY;
        end else begin
            state_q <= state_d;

            // The row stays frozen outside SCAN, so row_q doubles as the
            // latched row of the key being debounced or held.
            if (advance_row) begin
                row_q <= row_q + 2'd1;
            end

            if (state_q != SCAN || div_clr) begin
                div_q <= '0;
            end else if (div_q != DIV_LAST) begin
                div_q <= div_q + 1'b1;
            end

            if (deb_clr) begin
                deb_q <= '0;
            end else if (deb_inc && deb_q != DEB_MAX) begin
                deb_q <= deb_q + 1'b1;
            end

            if (latch_pat) begin
                pat_q <= col_s;
            end

            // Loaded on the edge into PRESSED, so the new code appears in the
            // same cycle as key_valid.
            if (load_code) begin
                key_code <= encode_key(row_q, col_index(pat_q));
            end
        end
    end

    assign row_n     = ~(4'b0001 << row_q);
    assign key_valid = (state_q == PRESSED);
    assign key_held  = (state_q == PRESSED) || (state_q == WAIT_REL) || (state_q == DEB_REL);

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Directed stimulus through a keypad model that shorts a pressed key's row to
//   its column. Expected key codes are queued when a press is issued; a monitor
//   pops and compares on every key_valid pulse and also watches row rotation,
//   pulse spacing and key_code stability.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    import keypad_scanner_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0][2:0] pressed;
    logic [3:0]      sb[$];

    int n_checks;
    int n_fail;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[r][c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int r, input int c);
        pressed[r][c] = 1'b1;
    endtask

    task automatic release_key(input int r, input int c);
        pressed[r][c] = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    // Edges until key_held drops, bounded.
    task automatic wait_held_fall(output int n);
        n = 0;
        while (key_held && n < 40) begin
            tick(1);
            n++;
        end
    endtask

    // Monitor: compares at the falling edge, away from the active edge.
    initial begin
        logic [3:0] prev_row;
        logic [3:0] prev_code;
        logic       prev_valid;
        logic       prev_rst;
        prev_row   = 4'b1110;
        prev_code  = NO_KEY;
        prev_valid = 1'b0;
        prev_rst   = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && !prev_rst) begin
                check("row_n exactly one low", 32'($countones(~row_n)), 32'd1);
                if (row_n != prev_row)
                    check("row_n rotation", 32'(row_n), 32'({prev_row[2:0], prev_row[3]}));
                if (key_valid) begin
                    check("key_valid back-to-back", 32'(prev_valid), 32'd0);
                    check("pending expectation at key_valid", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) check("key_code at key_valid", 32'(key_code), 32'(sb.pop_front()));
                end else begin
                    check("key_code stable without key_valid", 32'(key_code), 32'(prev_code));
                end
            end
            prev_row   = row_n;
            prev_code  = key_code;
            prev_valid = key_valid;
            prev_rst   = rst;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] walk_exp [4];
        logic [3:0] walk_got [4];
        int got;

        pressed = '0;
        rst     = 1'b1;
        n_checks = 0;
        n_fail   = 0;

        // Reset values.
        tick(2);
        check("reset row_n", 32'(row_n), 32'(4'b1110));
        check("reset key_code", 32'(key_code), 32'(NO_KEY));
        check("reset key_valid", 32'(key_valid), 32'd0);
        check("reset key_held", 32'(key_held), 32'd0);
        rst = 1'b0;
        tick(3);

        // "5": hold 40 cycles, one pulse, then timed release.
        // Release reaches col_s after 2 sync cycles; key_held must fall
        // 3..5 cycles after that, i.e. 5..7 cycles after col_n releases.
        sb.push_back(KEY_FIVE);
        press(1, 1);
        tick(40);
        wait_drain("press 5 pulse", 10);
        check("key 5 held while pressed", 32'(key_held), 32'd1);
        release_key(1, 1);
        wait_held_fall(n);
        check("key 5 release: key_held fall cycle in [5,7]", 32'(n >= 5 && n <= 7), 32'd1);
        tick(5);

        // "*" then "#", checking the row walk in between.
        sb.push_back(KEY_STAR);
        press(3, 0);
        tick(40);
        wait_drain("press star pulse", 10);
        release_key(3, 0);
        wait_held_fall(n);
        check("star release completes", 32'(key_held), 32'd0);
        walk_exp[0] = 4'b1110;
        walk_exp[1] = 4'b1101;
        walk_exp[2] = 4'b1011;
        walk_exp[3] = 4'b0111;
        walk_got[0] = row_n;
        got = 1;
        for (int i = 0; i < 40 && got < 4; i++) begin
            tick(1);
            if (row_n != walk_got[got-1]) begin
                walk_got[got] = row_n;
                got++;
            end
        end
        for (int i = 0; i < 4; i++) check($sformatf("row walk step %0d", i), 32'(walk_got[i]), 32'(walk_exp[i]));
        sb.push_back(KEY_HASH);
        press(3, 2);
        tick(40);
        wait_drain("press hash pulse", 10);
        release_key(3, 2);
        wait_held_fall(n);
        tick(5);

        // Bouncing "0": toggles every 2 cycles for 12 cycles, then stays
        // down (long enough to cover the worst-case scan latency).
        sb.push_back(KEY_ZERO);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) press(3, 1);
            else            release_key(3, 1);
            tick(2);
        end
        press(3, 1);
        tick(40);
        wait_drain("bounced 0 pulse", 10);
        release_key(3, 1);
        wait_held_fall(n);
        tick(5);

        // Hold "1", add and remove "9", then release "1": one pulse only.
        sb.push_back(KEY_ONE);
        press(0, 0);
        tick(40);
        wait_drain("press 1 pulse", 10);
        press(2, 2);
        tick(20);
        check("key_held with 1 and 9 down", 32'(key_held), 32'd1);
        release_key(2, 2);
        tick(20);
        check("key_held after 9 released", 32'(key_held), 32'd1);
        release_key(0, 0);
        wait_held_fall(n);
        check("key_held after 1 released", 32'(key_held), 32'd0);
        tick(5);

        // "7"+"8" in the same row: rejected, no pulse.
        press(2, 0);
        press(2, 1);
        tick(60);
        check("two keys in row: key_held", 32'(key_held), 32'd0);
        release_key(2, 0);
        release_key(2, 1);
        tick(10);

        // Reset while "3" is held: outputs reset, then "3" reported again.
        sb.push_back(KEY_THREE);
        press(0, 2);
        tick(40);
        wait_drain("press 3 pulse", 10);
        rst = 1'b1;
        tick(1);
        check("mid reset row_n", 32'(row_n), 32'(4'b1110));
        check("mid reset key_code", 32'(key_code), 32'(NO_KEY));
        check("mid reset key_valid", 32'(key_valid), 32'd0);
        check("mid reset key_held", 32'(key_held), 32'd0);
        tick(1);
        rst = 1'b0;
        sb.push_back(KEY_THREE);
        tick(40);
        wait_drain("press 3 pulse after reset", 10);
        check("key 3 held after reset", 32'(key_held), 32'd1);
        release_key(0, 2);
        wait_held_fall(n);
        tick(10);

        wait_drain("final queue empty", 10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
